// File: rtl/ixc_gfifo_pkg.sv
// Shared types and constants for the GFIFO drain block: record layout,
// serializer states and header field placement.
package ixc_gfifo_pkg;

    localparam int GF_DW     = 512;
    localparam int GF_MAXLEN = 512;
    localparam int GF_CBID_W = 20;
    localparam int GF_LEN_W  = 12;
    localparam int GF_SEQ_W  = 32;
    localparam int GF_HDR_W  = 64;

    // Header word field offsets
    localparam int HDR_CBID_LSB = 0;
    localparam int HDR_LEN_LSB  = 20;
    localparam int HDR_SEQ_LSB  = 32;

    typedef struct packed {
        logic [GF_CBID_W-1:0] cbid;
        logic [GF_LEN_W-1:0]  len;
        logic [GF_DW-1:0]     data;
    } gf_rec_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } drain_state_e;

    // Lengths above the payload size are stored as a full payload
    function automatic logic [GF_LEN_W-1:0] clamp_len(input logic [GF_LEN_W-1:0] len);
        return (len > GF_LEN_W'(GF_MAXLEN)) ? GF_LEN_W'(GF_MAXLEN) : len;
    endfunction

    function automatic logic [GF_HDR_W-1:0] make_hdr(
        input logic [GF_SEQ_W-1:0]  seqno,
        input logic [GF_LEN_W-1:0]  len,
        input logic [GF_CBID_W-1:0] cbid
    );
        logic [GF_HDR_W-1:0] hdr;
        hdr = '0;
        hdr[HDR_CBID_LSB +: GF_CBID_W] = cbid;
        hdr[HDR_LEN_LSB  +: GF_LEN_W]  = len;
        hdr[HDR_SEQ_LSB  +: GF_SEQ_W]  = seqno;
        return hdr;
    endfunction

endpackage

// File: rtl/ixc_gfifo_drain_if.sv
// CGF record bus from the ports plus the 64-bit upload stream.
// master = port/host side, slave = the drain block.
interface ixc_gfifo_drain_if;
    import ixc_gfifo_pkg::*;

    logic                 GFtsReq;
    logic [GF_CBID_W-1:0] GFcbid;
    logic [GF_LEN_W-1:0]  GFlen;
    logic [GF_DW-1:0]     GFidata;
    logic                 GFfull;

    logic                 ovalid;
    logic                 oready;
    logic [63:0]          odata;
    logic                 olast;

    modport master (
        output GFtsReq, GFcbid, GFlen, GFidata, oready,
        input  GFfull, ovalid, odata, olast
    );

    modport slave (
        input  GFtsReq, GFcbid, GFlen, GFidata, oready,
        output GFfull, ovalid, odata, olast
    );
endinterface

// File: rtl/ixc_gfifo_buf.sv
// Small first-word-fall-through record FIFO. The head entry is visible
// combinationally so the serializer can present a header the cycle after
// the record is written. Caller guarantees no push when full without a pop
// and no pop when empty.
module ixc_gfifo_buf #(
    parameter  int DEPTH = 4,
    parameter  int W     = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Pointer and occupancy update; power-of-two depth lets pointers wrap freely
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Control registers, cleared by reset (abandons all stored records)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy gates their use
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    assign rdata      = mem[rd_ptr_q];
    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/ixc_gfifo_drain.sv
// GFIFO drain: captures CGF records into a small buffer, raises GFfull
// backpressure, and serializes each record as a header word followed by
// ceil(len/64) payload words on a valid/ready stream.
module ixc_gfifo_drain
    import ixc_gfifo_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OW    = 64
) (
    input  logic                fclk,
    input  logic                rst,
    ixc_gfifo_drain_if.slave    bus,
    output logic                ovf,
    output logic                lenerr,
    output logic [GF_SEQ_W-1:0] seq
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int NW = GF_DW / OW;
    localparam int IW = $clog2(NW);
    localparam int LW = $clog2(OW);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] HIGH_C  = CW'(DEPTH - 1);

    gf_rec_t             wr_rec;
    gf_rec_t             head;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_next;
    logic                push;
    logic                pop;
    logic                hs;
    logic                len_over;
    logic                more;

    drain_state_e        state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                gffull_q, gffull_d;
    logic                ovf_q, ovf_d;
    logic                lenerr_q, lenerr_d;
    logic [GF_SEQ_W-1:0] seq_q, seq_d;

    logic [GF_LEN_W-1:0] n_dw;
    logic                last_dw;
    logic [LW-1:0]       rem;
    logic [OW-1:0]       tail_mask;
    logic [OW-1:0]       cur_word;
    logic [OW-1:0]       words [NW];

    logic                ovalid;
    logic                olast;
    logic [OW-1:0]       odata;

    // Incoming record with its length clamped to a full payload
    assign len_over    = bus.GFlen > GF_LEN_W'(GF_MAXLEN);
    assign wr_rec.cbid = bus.GFcbid;
    assign wr_rec.len  = clamp_len(bus.GFlen);
    assign wr_rec.data = bus.GFidata;

    // A pop frees a slot in the same cycle, so a full buffer still accepts
    assign hs   = ovalid & bus.oready;
    assign pop  = hs & olast;
    assign push = bus.GFtsReq & ((count != DEPTH_C) | pop);
    // Something remains to serialize after this cycle's pop
    assign more = (count > CW'(1)) | push;

    ixc_gfifo_buf #(
        .DEPTH (DEPTH),
        .W     ($bits(gf_rec_t))
    ) u_buf (
        .clk        (fclk),
        .rst        (rst),
        .push       (push),
        .pop        (pop),
        .wdata      (wr_rec),
        .rdata      (head),
        .count      (count),
        .count_next (count_next)
    );

    // Slice the head payload into output-width words
    genvar gi;
    generate
        for (gi = 0; gi < NW; gi++) begin : g_word
            assign words[gi] = head.data[gi*OW +: OW];
        end
    endgenerate

    assign n_dw      = (head.len + GF_LEN_W'(OW - 1)) >> LW;
    assign last_dw   = ({{(GF_LEN_W-IW){1'b0}}, idx_q} == (n_dw - GF_LEN_W'(1)));
    assign rem       = head.len[LW-1:0];
    assign tail_mask = (rem == '0) ? '1 : ((OW'(1) << rem) - OW'(1));
    assign cur_word  = words[idx_q];

    // Output word for the current state; head seq = seq minus records still held
    always_comb begin
        ovalid = 1'b0;
        olast  = 1'b0;
        odata  = '0;
        case (state_q)
            HDR: begin
                ovalid = 1'b1;
                olast  = (head.len == '0);
                odata  = make_hdr(seq_q - GF_SEQ_W'(count), head.len, head.cbid);
            end
            DATA: begin
                ovalid = 1'b1;
                olast  = last_dw;
                odata  = last_dw ? (cur_word & tail_mask) : cur_word;
            end
            default: ;
        endcase
    end

    // Serializer next state; chains straight into the next header when more is queued
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if ((count != '0) || push) begin
                    state_d = HDR;
                end
            end
            HDR: begin
                if (hs) begin
                    idx_d = '0;
                    if (olast) begin
                        state_d = more ? HDR : IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (hs) begin
                    if (olast) begin
                        state_d = more ? HDR : IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Backpressure keeps one slot of slack; flags are sticky until reset
    always_comb begin
        gffull_d = (count_next >= HIGH_C);
        ovf_d    = ovf_q | (bus.GFtsReq & ~push);
        lenerr_d = lenerr_q | (bus.GFtsReq & len_over);
        seq_d    = seq_q + GF_SEQ_W'(push);
    end

    // State and status registers
    always_ff @(posedge fclk) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            gffull_q <= 1'b0;
            ovf_q    <= 1'b0;
            lenerr_q <= 1'b0;
            seq_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            gffull_q <= gffull_d;
            ovf_q    <= ovf_d;
            lenerr_q <= lenerr_d;
            seq_q    <= seq_d;
        end
    end

    assign bus.GFfull = gffull_q;
    assign bus.ovalid = ovalid;
    assign bus.olast  = olast;
    assign bus.odata  = odata;
    assign ovf        = ovf_q;
    assign lenerr     = lenerr_q;
    assign seq        = seq_q;

endmodule

// File: tb/tb_ixc_gfifo_drain.sv
// Directed bench for ixc_gfifo_drain. A queue-based model expands each
// accepted record into its expected words; one process compares the DUT
// against it every cycle, and literal values pin key results.
module tb_ixc_gfifo_drain;
    import ixc_gfifo_pkg::*;

    localparam int DEPTH = 4;

    logic        fclk = 1'b0;
    logic        rst  = 1'b1;
    logic        ovf;
    logic        lenerr;
    logic [31:0] seq;

    always #5 fclk = ~fclk;

    ixc_gfifo_drain_if bus();

    ixc_gfifo_drain #(.DEPTH(DEPTH), .OW(64)) dut (
        .fclk   (fclk),
        .rst    (rst),
        .bus    (bus),
        .ovf    (ovf),
        .lenerr (lenerr),
        .seq    (seq)
    );

    int vectors = 0;
    int miscompares = 0;

    // Model state
    logic [63:0] mw_data[$];
    logic        mw_last[$];
    int          m_nrec = 0;
    logic [31:0] m_seq = 0;
    logic        m_ovf = 0, m_lenerr = 0, m_full = 0;

    // DUT word log (handshaken words)
    logic [63:0] log_d[$];
    logic        log_l[$];
    logic [63:0] ref_d[$];

    logic        chk_en = 0;
    logic        rst_prev = 1;
    logic        rand_ready = 0;
    logic        stall_prev = 0;
    logic [63:0] prev_d = 0;
    logic        prev_l = 0;
    logic        m_hs;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expand an accepted record into header + payload words from the rules
    task automatic model_push(input logic [19:0] cbid, input logic [11:0] len_in, input logic [511:0] data);
        int l;
        int nw;
        logic [63:0] w;
        l  = (len_in > 512) ? 512 : int'(len_in);
        nw = (l + 63) / 64;
        mw_data.push_back({m_seq, 12'(l), cbid});
        mw_last.push_back(nw == 0);
        for (int k = 0; k < nw; k++) begin
            w = data[64*k +: 64];
            for (int b = 0; b < 64; b++) begin
                if (64*k + b >= l) w[b] = 1'b0;
            end
            mw_data.push_back(w);
            mw_last.push_back(k == nw - 1);
        end
    endtask

    // Compare process: check outputs, then advance the model by this cycle's events
    initial begin
        forever begin
            @(negedge fclk);
            if (chk_en) begin
                check("ovalid", bus.ovalid, mw_data.size() != 0);
                check("GFfull", bus.GFfull, m_full);
                check("ovf", ovf, m_ovf);
                check("lenerr", lenerr, m_lenerr);
                check("seq", seq, m_seq);
                if (mw_data.size() != 0) begin
                    check("odata", bus.odata, mw_data[0]);
                    check("olast", bus.olast, mw_last[0]);
                end
                if (rst_prev) begin
                    check("rst_odata", bus.odata, 64'd0);
                    check("rst_olast", bus.olast, 1'b0);
                end
                if (stall_prev) begin
                    check("hold_ovalid", bus.ovalid, 1'b1);
                    check("hold_odata", bus.odata, prev_d);
                    check("hold_olast", bus.olast, prev_l);
                end
                stall_prev = bus.ovalid && !bus.oready && !rst;
                prev_d = bus.odata;
                prev_l = bus.olast;
                if (bus.ovalid && bus.oready) begin
                    log_d.push_back(bus.odata);
                    log_l.push_back(bus.olast);
                end
                if (rst) begin
                    mw_data.delete();
                    mw_last.delete();
                    m_nrec = 0; m_seq = 0; m_ovf = 0; m_lenerr = 0; m_full = 0;
                end else begin
                    m_hs = bus.oready && (mw_data.size() != 0);
                    if (m_hs) begin
                        if (mw_last[0]) m_nrec--;
                        void'(mw_data.pop_front());
                        void'(mw_last.pop_front());
                    end
                    if (bus.GFtsReq) begin
                        if (bus.GFlen > 12'd512) m_lenerr = 1'b1;
                        if (m_nrec < DEPTH) begin
                            model_push(bus.GFcbid, bus.GFlen, bus.GFidata);
                            m_nrec++;
                            m_seq++;
                        end else begin
                            m_ovf = 1'b1;
                        end
                    end
                    m_full = (m_nrec >= DEPTH - 1);
                end
            end
            rst_prev = rst;
        end
    end

    task automatic tick();
        @(posedge fclk);
        #1;
        if (rand_ready) bus.oready = 1'($urandom_range(0, 1));
    endtask

    task automatic strobe(input logic [19:0] c, input logic [11:0] l, input logic [511:0] d);
        bus.GFtsReq = 1'b1;
        bus.GFcbid  = c;
        bus.GFlen   = l;
        bus.GFidata = d;
        tick();
        bus.GFtsReq = 1'b0;
    endtask

    // Send honouring GFfull, as a port would
    task automatic send_fc(input logic [19:0] c, input logic [11:0] l, input logic [511:0] d);
        int n = 0;
        while (bus.GFfull && n < 200) begin
            tick();
            n++;
        end
        check("gffull_wait", bus.GFfull, 1'b0);
        strobe(c, l, d);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (mw_data.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_done", 64'(mw_data.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        bus.GFtsReq = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [511:0] inc_bytes();
        logic [511:0] d;
        for (int i = 0; i < 64; i++) d[8*i +: 8] = 8'(i);
        return d;
    endfunction

    function automatic logic [511:0] rand_data();
        logic [511:0] d;
        for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
        return d;
    endfunction

    logic [511:0] rd[20];
    logic [11:0]  rl[20];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        bus.GFtsReq = 0; bus.GFcbid = 0; bus.GFlen = 0; bus.GFidata = 0;
        bus.oready = 1'b1;
        repeat (3) @(posedge fclk);
        #1;
        rst = 1'b0;
        chk_en = 1'b1;

        // Single record, len=100, incrementing bytes
        log_d.delete(); log_l.delete();
        strobe(20'h12345, 12'd100, inc_bytes());
        wait_drain(50);
        check("t1_words", 64'(log_d.size()), 64'd3);
        if (log_d.size() == 3) begin
            check("t1_hdr", log_d[0], 64'h00000000_06412345);
            check("t1_w1", log_d[1], 64'h07060504_03020100);
            check("t1_w2", log_d[2], 64'h0000000C_0B0A0908);
            check("t1_last", {log_l[0], log_l[1], log_l[2]}, 3'b001);
        end

        // len=0 then len=512
        log_d.delete(); log_l.delete();
        strobe(20'hABCDE, 12'd0, rand_data());
        wait_drain(50);
        check("t2_words0", 64'(log_d.size()), 64'd1);
        if (log_d.size() == 1) begin
            check("t2_hdr0", log_d[0], 64'h00000001_000ABCDE);
            check("t2_last0", log_l[0], 1'b1);
        end
        log_d.delete(); log_l.delete();
        strobe(20'h00001, 12'd512, rand_data());
        wait_drain(50);
        check("t2_words512", 64'(log_d.size()), 64'd9);
        if (log_d.size() == 9) begin
            check("t2_hdr512", log_d[0], 64'h00000002_20000001);
            check("t2_last8", log_l[7], 1'b0);
            check("t2_last9", log_l[8], 1'b1);
        end

        // Five back-to-back with the output stalled
        pulse_reset();
        log_d.delete(); log_l.delete();
        bus.oready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            strobe(20'(i + 16), 12'd64, rand_data());
            if (i == 1) check("t3_full_after2", bus.GFfull, 1'b0);
            if (i == 2) check("t3_full_after3", bus.GFfull, 1'b1);
        end
        check("t3_seq", seq, 32'd4);
        check("t3_ovf", ovf, 1'b1);
        bus.oready = 1'b1;
        wait_drain(50);
        check("t3_words", 64'(log_d.size()), 64'd8);
        if (log_d.size() == 8) begin
            for (int i = 0; i < 4; i++) check("t3_hdr_seq", log_d[2*i][63:32], 32'(i));
        end

        // 20 records, free-flowing then with random stalls
        for (int i = 0; i < 20; i++) begin
            rl[i] = 12'((i * 29) % 513);
            rd[i] = rand_data();
        end
        pulse_reset();
        log_d.delete(); log_l.delete();
        for (int i = 0; i < 20; i++) send_fc(20'(i * 32'h1111 + 1), rl[i], rd[i]);
        wait_drain(400);
        ref_d = log_d;
        pulse_reset();
        log_d.delete(); log_l.delete();
        rand_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_fc(20'(i * 32'h1111 + 1), rl[i], rd[i]);
        wait_drain(2000);
        rand_ready = 1'b0;
        bus.oready = 1'b1;
        check("t4_len", 64'(log_d.size()), 64'(ref_d.size()));
        if (log_d.size() == ref_d.size()) begin
            for (int i = 0; i < ref_d.size(); i++) check("t4_word", log_d[i], ref_d[i]);
        end

        // Over-length record
        log_d.delete(); log_l.delete();
        strobe(20'h00777, 12'd700, rand_data());
        wait_drain(50);
        check("t5_lenerr", lenerr, 1'b1);
        check("t5_words", 64'(log_d.size()), 64'd9);
        if (log_d.size() != 0) check("t5_hdrlen", log_d[0][31:20], 12'd512);

        // Reset in the middle of a record with two more buffered
        bus.oready = 1'b0;
        for (int i = 0; i < 3; i++) strobe(20'(i + 32), 12'd512, rand_data());
        bus.oready = 1'b1;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_ovalid", bus.ovalid, 1'b0);
        check("t6_olast", bus.olast, 1'b0);
        check("t6_odata", bus.odata, 64'd0);
        check("t6_full", bus.GFfull, 1'b0);
        check("t6_seq", seq, 32'd0);
        check("t6_lenerr", lenerr, 1'b0);
        check("t6_ovf", ovf, 1'b0);
        log_d.delete(); log_l.delete();
        strobe(20'h55555, 12'd8, {504'd0, 8'hA5});
        wait_drain(50);
        check("t6_words", 64'(log_d.size()), 64'd2);
        if (log_d.size() == 2) begin
            check("t6_hdr", log_d[0], 64'h00000000_00855555);
            check("t6_w1", log_d[1], 64'h00000000_000000A5);
        end

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
